output_port_queue: RTL and testbench
====================================

// Module: output_port_queue
// PURPOSE
//  Per-port egress packet queue of the 4-port router; sits directly upstream of the port receiver.
//  Buffers bytes written by the switch fabric and tracks complete packets.
//  Presents one complete packet at a time to the receiver on data/ready/read.
//  One instance per port (0..3), driving data_N/ready_N and sampling read_N.
// PARAMETERS
//  DATA_W   8    width of one stored byte and of data
//  DEPTH    64   FIFO capacity in bytes; power of two, >= 4
//  ADDR_W   6    log2(DEPTH); pointers are ADDR_W+1 bits wide, MSB used as the wrap bit
// PORTS
//  clock      in   1           rising-edge clock
//  reset_n    in   1           asynchronous, active-low reset
//  wr_valid   in   1           fabric presents a byte this cycle
//  wr_data    in   DATA_W      byte from fabric
//  wr_eop     in   1           wr_data is the last byte of its packet
//  wr_ready   out  1           queue can accept a byte (not full)
//  read       in   1           receiver requests next byte
//  ready      out  1           packet available / transfer in progress
//  data       out  DATA_W      registered output byte
//  level      out  ADDR_W+1    bytes currently stored (0..DEPTH)
//  pkt_count  out  ADDR_W+1    complete packets currently stored
// BEHAVIOUR
//  Reset (async, reset_n=0): pointers=0, level=0, pkt_count=0, state=IDLE, data=0, ready=0, wr_ready=1.
//  Storage: DEPTH x (DATA_W+1) array; each entry = {eop, byte}.
//  Write: wr_valid & wr_ready at edge -> store {wr_eop, wr_data}, wr_ptr+1, level+1.
//  Writes with wr_ready=0 are ignored (no store, no error).
//  wr_ready = (level != DEPTH), combinational from registered level.
//  pkt_count +1 at an edge that writes an eop byte.
//  FSM states: IDLE, SEND, GAP.
//   IDLE: ready = (pkt_count != 0).
//    On read & ready: pop head into data, go SEND (or GAP if the popped byte has eop).
//   SEND: ready = 1.
//    On read: pop next byte into data.
//    On read=0: hold data, no pop.
//    The popped byte carrying eop -> GAP.
//   GAP: ready = 0 for exactly one cycle (packet boundary), then IDLE.
//  Latency: data updates at the same edge that samples read=1, so the byte is visible in the following cycle.
//  First byte of a packet appears one cycle after the first read; at most 1 byte popped per edge.
//  At the edge popping an eop byte: pkt_count -1, level -1.
//  Simultaneous events: eop write and eop pop at the same edge -> pkt_count unchanged.
//   Any write plus pop -> level unchanged.
//  Pop from empty never occurs: SEND only exists while a complete packet is stored.
//  Pointers wrap modulo DEPTH; full/empty are decided by level (pointer MSBs for cross-check).
//  Partial packet (no eop yet) is never offered: ready stays 0 until its eop byte is written.
//  Reset mid-transfer: immediate return to the reset values above; partial packets are discarded.
//  Widths: level/pkt_count never exceed DEPTH and never underflow.
//   Assertions flag wr beyond full, pop beyond empty, and pkt_count > level.
// TESTING
//  1 Reset: reset_n=0 for 2 cycles -> ready=0, data=8'h00, wr_ready=1, level=0, pkt_count=0.
//  2 Basic: write A1,A2,A3,A4 (eop on A4), read held 1 -> ready=1 the cycle after the A4 write.
//    data=A1,A2,A3,A4 on 4 consecutive cycles; ready=0 one cycle (GAP); level=0.
//  3 Pause: same packet, read=1,1,0,0,1,1 -> data A1,A2 then holds A2 two cycles, then A3,A4.
//    ready stays 1 until A4 is popped.
//  4 Full/wrap: write 64 bytes (eop every 16th) -> wr_ready=0 at level=64, extra write ignored.
//    Read one packet -> wr_ready=1; refill 16 bytes past the wrap; readback order intact (4 packets).
//  5 Simultaneous: packet B in flight; B's eop pop coincides with C's eop write.
//    -> pkt_count unchanged; after GAP ready=1 and C is delivered intact.
//  6 Reset mid-transfer: reset_n=0 after 2 of 4 bytes read -> ready=0, level=0 immediately.
//    New 2-byte packet 55,66 after release is delivered correctly.

Source files
------------

// File: rtl/output_port_queue_if.sv
// Egress-queue port bundle: fabric write side plus receiver read side.
// master = fabric/receiver side, slave = the queue itself.
interface output_port_queue_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_eop;
  logic              wr_ready;
  logic              read;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [ADDR_W:0]   level;
  logic [ADDR_W:0]   pkt_count;

  modport master (
    output wr_valid, wr_data, wr_eop, read,
    input  wr_ready, ready, data, level, pkt_count
  );

  modport slave (
    input  wr_valid, wr_data, wr_eop, read,
    output wr_ready, ready, data, level, pkt_count
  );
endinterface

// File: rtl/output_port_queue.sv
// Per-port egress packet FIFO: stores {eop, byte} entries from the fabric and
// offers one complete packet at a time to the port receiver.
module output_port_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input logic                 clock,
  input logic                 reset_n,
  output_port_queue_if.slave  q
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] FULL_LEVEL = PW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  logic [DATA_W:0]   mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     level_r;
  logic [PW-1:0]     pkt_r;
  state_t            state;
  logic              ready_r;
  logic [DATA_W-1:0] data_r;

  logic              wr_en;
  logic              pop;
  logic [DATA_W:0]   head;
  logic              head_eop;
  logic [PW-1:0]     level_nxt;
  logic [PW-1:0]     pkt_nxt;
  state_t            state_nxt;
  logic              ready_nxt;

  assign q.wr_ready  = (level_r != FULL_LEVEL);
  assign q.ready     = ready_r;
  assign q.data      = data_r;
  assign q.level     = level_r;
  assign q.pkt_count = pkt_r;

  assign wr_en    = q.wr_valid & q.wr_ready;
  assign pop      = q.read & ready_r;
  assign head     = mem[rd_ptr[ADDR_W-1:0]];
  assign head_eop = head[DATA_W];

  // Occupancy bookkeeping: a write and a pop at the same edge cancel out.
  always_comb begin
    level_nxt = level_r + PW'(wr_en) - PW'(pop);
    pkt_nxt   = pkt_r + PW'(wr_en & q.wr_eop) - PW'(pop & head_eop);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = head_eop ? GAP : SEND;
      SEND:    if (pop && head_eop) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ready is registered; in IDLE it only rises once a whole packet is stored.
  always_comb begin
    ready_nxt = 1'b0;
    case (state_nxt)
      IDLE:    ready_nxt = (pkt_nxt != '0);
      SEND:    ready_nxt = 1'b1;
      default: ready_nxt = 1'b0;
    endcase
  end

  // Byte storage carries no reset; only the pointers define validity.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= {q.wr_eop, q.wr_data};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_r <= '0;
      pkt_r   <= '0;
      state   <= IDLE;
      ready_r <= 1'b0;
      data_r  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        data_r <= head[DATA_W-1:0];
      end
      level_r <= level_nxt;
      pkt_r   <= pkt_nxt;
      state   <= state_nxt;
      ready_r <= ready_nxt;
    end
  end

  a_level_bound: assert property (@(posedge clock) disable iff (!reset_n)
    level_r <= FULL_LEVEL);
  a_no_pop_empty: assert property (@(posedge clock) disable iff (!reset_n)
    !(pop && level_r == '0));
  a_pkt_le_level: assert property (@(posedge clock) disable iff (!reset_n)
    pkt_r <= level_r);
  a_ptr_level: assert property (@(posedge clock) disable iff (!reset_n)
    (wr_ptr - rd_ptr) == level_r);

endmodule

// File: tb/tb_output_port_queue.sv
// Directed bench for output_port_queue: queue-level reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_output_port_queue;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  output_port_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) qif ();

  output_port_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .q       (qif.slave)
  );

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queue, packet presence derived by counting eops.
  logic [8:0] mq[$];
  bit         m_in_pkt = 1'b0;
  bit         m_gap    = 1'b0;
  logic [7:0] m_data   = 8'h00;

  function automatic int m_pkts();
    int n = 0;
    foreach (mq[i]) if (mq[i][8]) n++;
    return n;
  endfunction

  function automatic bit m_ready();
    if (m_gap) return 1'b0;
    if (m_in_pkt) return 1'b1;
    return (m_pkts() > 0);
  endfunction

  initial begin
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        mq.delete();
        m_in_pkt = 1'b0;
        m_gap    = 1'b0;
        m_data   = 8'h00;
      end else begin
        bit r, wok;
        logic [8:0] e;
        r   = m_ready();
        wok = qif.wr_valid && (mq.size() < DEPTH);
        if (qif.read && r) begin
          e        = mq.pop_front();
          m_data   = e[7:0];
          m_in_pkt = !e[8];
          m_gap    = e[8];
        end else if (m_gap) begin
          m_gap = 1'b0;
        end
        if (wok) mq.push_back({qif.wr_eop, qif.wr_data});
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (started) begin
        chk("ready",     int'(qif.ready),     int'(m_ready()));
        chk("data",      int'(qif.data),      int'(m_data));
        chk("wr_ready",  int'(qif.wr_ready),  int'(mq.size() < DEPTH));
        chk("level",     int'(qif.level),     mq.size());
        chk("pkt_count", int'(qif.pkt_count), m_pkts());
      end
    end
  end

  task automatic cyc(input logic wv, input logic [7:0] wd, input logic we, input logic rd);
    qif.wr_valid = wv;
    qif.wr_data  = wd;
    qif.wr_eop   = we;
    qif.read     = rd;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_rd [6];
    logic       rd_seq [6];
    qif.wr_valid = 1'b0;
    qif.wr_data  = 8'h00;
    qif.wr_eop   = 1'b0;
    qif.read     = 1'b0;

    // 1 reset
    #2 reset_n = 1'b0;
    started = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", int'(qif.ready), 0);
    chk("rst_data", int'(qif.data), 8'h00);
    chk("rst_wr_ready", int'(qif.wr_ready), 1);
    chk("rst_level", int'(qif.level), 0);
    chk("rst_pkt", int'(qif.pkt_count), 0);
    reset_n = 1'b1;
    cyc(0, 8'h00, 0, 0);

    // 2 basic, read held high throughout
    cyc(1, 8'hA1, 0, 1);
    cyc(1, 8'hA2, 0, 1);
    cyc(1, 8'hA3, 0, 1);
    chk("basic_partial_ready", int'(qif.ready), 0);
    cyc(1, 8'hA4, 1, 1);
    chk("basic_ready_after_eop", int'(qif.ready), 1);
    chk("basic_pkt", int'(qif.pkt_count), 1);
    cyc(0, 8'h00, 0, 1); chk("basic_d1", int'(qif.data), 8'hA1);
    cyc(0, 8'h00, 0, 1); chk("basic_d2", int'(qif.data), 8'hA2);
    cyc(0, 8'h00, 0, 1); chk("basic_d3", int'(qif.data), 8'hA3);
    chk("basic_ready_mid", int'(qif.ready), 1);
    cyc(0, 8'h00, 0, 1); chk("basic_d4", int'(qif.data), 8'hA4);
    chk("basic_gap", int'(qif.ready), 0);
    chk("basic_level", int'(qif.level), 0);
    cyc(0, 8'h00, 0, 0);
    chk("basic_idle_ready", int'(qif.ready), 0);

    // 3 pause
    cyc(1, 8'hA1, 0, 0);
    cyc(1, 8'hA2, 0, 0);
    cyc(1, 8'hA3, 0, 0);
    cyc(1, 8'hA4, 1, 0);
    exp_rd = '{8'hA1, 8'hA2, 8'hA2, 8'hA2, 8'hA3, 8'hA4};
    rd_seq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      cyc(0, 8'h00, 0, rd_seq[i]);
      chk($sformatf("pause_d%0d", i), int'(qif.data), int'(exp_rd[i]));
      chk($sformatf("pause_rdy%0d", i), int'(qif.ready), (i < 5) ? 1 : 0);
    end
    cyc(0, 8'h00, 0, 0);

    // 4 full and wrap: 4 packets of 16 bytes
    for (int i = 0; i < 64; i++) cyc(1, 8'(i), ((i % 16) == 15), 0);
    chk("full_level", int'(qif.level), 64);
    chk("full_wr_ready", int'(qif.wr_ready), 0);
    chk("full_pkt", int'(qif.pkt_count), 4);
    cyc(1, 8'hEE, 1, 0);
    chk("full_ignored_level", int'(qif.level), 64);
    chk("full_ignored_pkt", int'(qif.pkt_count), 4);
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 0, 1);
    chk("full_first_pkt_last", int'(qif.data), 8'h0F);
    chk("full_after_wr_ready", int'(qif.wr_ready), 1);
    chk("full_after_level", int'(qif.level), 48);
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h40 + i), (i == 15), 0);
    chk("wrap_level", int'(qif.level), 64);
    for (int i = 0; i < 70; i++) cyc(0, 8'h00, 0, 1);
    chk("wrap_last_byte", int'(qif.data), 8'h4F);
    chk("wrap_drained", int'(qif.level), 0);
    cyc(0, 8'h00, 0, 0);

    // 5 eop pop of B coincides with eop write of C
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'hB0 + i), (i == 3), 0);
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'hC0 + i), (i == 3), 1);
    chk("simul_data", int'(qif.data), 8'hB3);
    chk("simul_pkt", int'(qif.pkt_count), 1);
    chk("simul_level", int'(qif.level), 4);
    chk("simul_gap", int'(qif.ready), 0);
    cyc(0, 8'h00, 0, 0);
    chk("simul_ready_after_gap", int'(qif.ready), 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 8'h00, 0, 1);
      chk($sformatf("simul_c%0d", i), int'(qif.data), 8'hC0 + i);
    end
    cyc(0, 8'h00, 0, 0);

    // 6 reset mid-transfer
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'hD0 + i), (i == 3), 0);
    cyc(0, 8'h00, 0, 1);
    cyc(0, 8'h00, 0, 1);
    chk("mid_data", int'(qif.data), 8'hD1);
    qif.read = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", int'(qif.ready), 0);
    chk("mid_rst_level", int'(qif.level), 0);
    chk("mid_rst_pkt", int'(qif.pkt_count), 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    cyc(1, 8'h55, 0, 0);
    cyc(1, 8'h66, 1, 0);
    chk("post_rst_ready", int'(qif.ready), 1);
    cyc(0, 8'h00, 0, 1); chk("post_rst_d0", int'(qif.data), 8'h55);
    cyc(0, 8'h00, 0, 1); chk("post_rst_d1", int'(qif.data), 8'h66);
    cyc(0, 8'h00, 0, 0);
    chk("post_rst_level", int'(qif.level), 0);
    cyc(0, 8'h00, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
